clk_divider_multi: RTL and testbench

- Parametrised multi-channel programmable clock divider. Each of CHANNELS outputs runs with its own period and high time, all derived from inclk.
- Divisor and duty changes are double-buffered and take effect only at a period boundary, so they never glitch.
- Enable uses a graceful-stop state machine: a disabled channel finishes its current period before idling low.
- Feeds slower timing domains and strobe generators in the FPGA fabric.

---
 rtl/clk_divider_multi.sv | 135 +++++++++++++
 tb/tb_clk_divider_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable clock divider with glitch-free reconfiguration
module clk_divider_multi #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int RESET_DIV = 2
) (
    input  logic                      inclk,
    input  logic                      Reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] div_count,
    input  logic [CHANNELS*WIDTH-1:0] high_count,
    output logic [CHANNELS-1:0]       outclk,
    output logic [CHANNELS-1:0]       outclk_n,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS-1:0]       cfg_err
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] RST_P = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] RST_H = WIDTH'(RESET_DIV / 2);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    assign outclk_n = ~outclk;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state, state_d;
        logic [WIDTH-1:0] cnt, cnt_d, p, h, pp, hp;
        logic [WIDTH-1:0] div, high, high_clamp;
        logic             pend_v, wrap, load_ok;
        logic             oc_q, oc_d, tick_q, tick_d, err_q;

        assign div     = div_count[c*WIDTH +: WIDTH];
        assign high    = high_count[c*WIDTH +: WIDTH];
        assign wrap    = (state != IDLE) && (cnt == p - ONE);
        assign load_ok = load[c] && (div >= TWO);

        // High time must leave the last cycle of every period low.
        always_comb begin
            high_clamp = high;
            if (high == '0)
                high_clamp = ONE;
            else if (high >= div)
                high_clamp = div - ONE;
        end

        always_ff @(posedge inclk or posedge Reset) begin
            if (Reset)
                state <= IDLE;
            else
                state <= state_d;
        end

        always_comb begin
            state_d = state;
            case (state)
                IDLE:     if (enable[c]) state_d = RUN;
                RUN:      if (!enable[c]) state_d = STOPPING;
                STOPPING: begin
                    if (enable[c])
                        state_d = RUN;
                    else if (wrap)
                        state_d = IDLE;
                end
                default:  state_d = IDLE;
            endcase
        end

        always_comb begin
            cnt_d  = cnt;
            oc_d   = 1'b0;
            tick_d = 1'b0;
            case (state)
                IDLE: begin
                    cnt_d = '0;
                    if (enable[c]) begin
                        oc_d   = 1'b1;
                        tick_d = 1'b1;
                    end
                end
                default: begin
                    cnt_d = wrap ? '0 : cnt + ONE;
                    // H never exceeds P-1, so the stop edge always lands on a low phase.
                    if (!(state == STOPPING && !enable[c] && wrap)) begin
                        oc_d   = (cnt_d < h);
                        tick_d = wrap;
                    end
                end
            endcase
        end

        always_ff @(posedge inclk or posedge Reset) begin
            if (Reset) begin
                cnt    <= '0;
                p      <= RST_P;
                h      <= RST_H;
                pp     <= '0;
                hp     <= '0;
                pend_v <= 1'b0;
                oc_q   <= 1'b0;
                tick_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                cnt    <= cnt_d;
                oc_q   <= oc_d;
                tick_q <= tick_d;
                err_q  <= load[c] && (div < TWO);
                if (load_ok && (state == IDLE || wrap)) begin
                    p      <= div;
                    h      <= high_clamp;
                    pend_v <= 1'b0;
                end else if (load_ok) begin
                    pp     <= div;
                    hp     <= high_clamp;
                    pend_v <= 1'b1;
                end else if (wrap && pend_v) begin
                    p      <= pp;
                    h      <= hp;
                    pend_v <= 1'b0;
                end
            end
        end

        assign outclk[c]  = oc_q;
        assign tick[c]    = tick_q;
        assign cfg_err[c] = err_q;
        assign active[c]  = (state != IDLE);
    end
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - self-checking bench for clk_divider_multi
module tb_clk_divider_multi;
    localparam int W  = 32;
    localparam int CH = 4;
    localparam int RD = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;

    logic              inclk = 1'b0;
    logic              Reset = 1'b1;
    logic [CH-1:0]     enable = '0, load = '0;
    logic [CH*W-1:0]   div_count = '0, high_count = '0;
    logic [CH-1:0]     outclk, outclk_n, tick, active, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    clk_divider_multi #(.WIDTH(W), .CHANNELS(CH), .RESET_DIV(RD)) dut (
        .inclk(inclk), .Reset(Reset), .enable(enable), .load(load),
        .div_count(div_count), .high_count(high_count),
        .outclk(outclk), .outclk_n(outclk_n), .tick(tick),
        .active(active), .cfg_err(cfg_err)
    );

    always #5 inclk = ~inclk;

    // Reference: each period is a queue of H ones followed by P-H zeros.
    int m_mode [CH];
    int m_p [CH], m_h [CH], m_pp [CH], m_hp [CH];
    bit m_pend [CH], m_out [CH], m_tick [CH], m_err [CH];
    bit wave [CH][$];

    typedef struct {
        int div; int hi; bit err; int exp_p; int exp_h;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input int c, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, c, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = M_IDLE; m_p[c] = RD; m_h[c] = RD / 2;
            m_pend[c] = 0; m_out[c] = 0; m_tick[c] = 0; m_err[c] = 0;
            wave[c].delete();
        end
    endtask

    task automatic start_period(input int c);
        wave[c].delete();
        for (int i = 0; i < m_p[c]; i++) wave[c].push_back(i < m_h[c]);
        m_out[c]  = wave[c].pop_front();
        m_tick[c] = 1;
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            int dv, hv, hc;
            bit en, ok;
            en = enable[c];
            dv = int'(div_count[c*W +: W]);
            hv = int'(high_count[c*W +: W]);
            hc = (hv == 0) ? 1 : ((hv >= dv) ? dv - 1 : hv);
            m_err[c] = load[c] && dv < 2;
            ok = load[c] && dv >= 2;
            if (m_mode[c] == M_IDLE) begin
                if (ok) begin m_p[c] = dv; m_h[c] = hc; end
                if (en) begin m_mode[c] = M_RUN; start_period(c); end
                else begin m_out[c] = 0; m_tick[c] = 0; end
            end else if (wave[c].size() == 0) begin
                if (ok) begin m_p[c] = dv; m_h[c] = hc; m_pend[c] = 0; end
                else if (m_pend[c]) begin m_p[c] = m_pp[c]; m_h[c] = m_hp[c]; m_pend[c] = 0; end
                if (m_mode[c] == M_STOP && !en) begin
                    m_mode[c] = M_IDLE; m_out[c] = 0; m_tick[c] = 0;
                end else begin
                    m_mode[c] = en ? M_RUN : M_STOP;
                    start_period(c);
                end
            end else begin
                if (ok) begin m_pp[c] = dv; m_hp[c] = hc; m_pend[c] = 1; end
                m_out[c]  = wave[c].pop_front();
                m_tick[c] = 0;
                m_mode[c] = en ? M_RUN : M_STOP;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            check("outclk",   c, int'(outclk[c]),   int'(m_out[c]));
            check("outclk_n", c, int'(outclk_n[c]), int'(!m_out[c]));
            check("tick",     c, int'(tick[c]),     int'(m_tick[c]));
            check("active",   c, int'(active[c]),   int'(m_mode[c] != M_IDLE));
            check("cfg_err",  c, int'(cfg_err[c]),  int'(m_err[c]));
        end
    endtask

    task automatic cycle();
        @(posedge inclk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_cfg(input int c, input int dv, input int hv);
        div_count[c*W +: W]  = W'(dv);
        high_count[c*W +: W] = W'(hv);
    endtask

    task automatic do_load(input int c, input int dv, input int hv);
        set_cfg(c, dv, hv);
        load[c] = 1'b1;
        cycle();
        load[c] = 1'b0;
    endtask

    task automatic wait_idle(input int c);
        int k;
        k = 0;
        while (active[c] && k < 64) begin cycle(); k++; end
        check("wait_idle", c, int'(active[c]), 0);
    endtask

    initial begin
        int highs, ticks, n;
        vecs[0] = '{1, 0, 1, 2, 1};
        vecs[1] = '{6, 0, 0, 6, 1};
        vecs[2] = '{6, 9, 0, 6, 5};
        vecs[3] = '{0, 5, 1, 6, 5};
        vecs[4] = '{5, 1, 0, 5, 1};
        vecs[5] = '{3, 2, 0, 3, 2};
        vecs[6] = '{7, 7, 0, 7, 6};
        vecs[7] = '{4, 3, 0, 4, 3};

        model_reset();
        repeat (3) @(posedge inclk);
        #1;
        check_all();
        @(negedge inclk);
        Reset = 1'b0;

        // Default divider on channel 0
        enable[0] = 1'b1;
        repeat (10) cycle();

        // Channel 1: 5/1 then reconfigure mid-period to 10/3
        do_load(1, 5, 1);
        enable[1] = 1'b1;
        repeat (7) cycle();
        set_cfg(1, 10, 3);
        load[1] = 1'b1;
        cycle();
        load[1] = 1'b0;
        repeat (25) cycle();

        // Load capture / clamp table on channel 3
        for (int i = 0; i < 8; i++) begin
            do_load(3, vecs[i].div, vecs[i].hi);
            check("tbl_err", 3, int'(cfg_err[3]), int'(vecs[i].err));
            enable[3] = 1'b1;
            highs = 0; ticks = 0;
            for (int k = 0; k < vecs[i].exp_p; k++) begin
                cycle();
                highs += int'(outclk[3]);
                ticks += int'(tick[3]);
            end
            check("tbl_high", 3, highs, vecs[i].exp_h);
            check("tbl_tick", 3, ticks, 1);
            enable[3] = 1'b0;
            wait_idle(3);
        end

        // Channel 2 graceful stop from cnt=1
        do_load(2, 8, 4);
        enable[2] = 1'b1;
        repeat (2) cycle();
        enable[2] = 1'b0;
        highs = 0; n = 0;
        while (active[2] && n < 40) begin
            cycle(); n++;
            highs += int'(outclk[2]);
        end
        check("stop_len", 2, n, 7);
        check("stop_high", 2, highs, 2);
        enable[2] = 1'b1;
        repeat (3) cycle();
        enable[2] = 1'b0;
        repeat (2) cycle();
        enable[2] = 1'b1;
        repeat (12) cycle();
        enable[2] = 1'b0;
        wait_idle(2);

        // All four channels, randomized duty, loads and enable toggles
        enable = '0;
        for (int c = 0; c < CH; c++) wait_idle(c);
        do_load(0, 2, $urandom_range(0, 3));
        do_load(1, 3, $urandom_range(0, 4));
        do_load(2, 7, $urandom_range(0, 9));
        do_load(3, 16, $urandom_range(0, 18));
        enable = '1;
        repeat (40) cycle();
        for (int k = 0; k < 100; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    set_cfg(c, $urandom_range(0, 12), $urandom_range(0, 14));
                    load[c] = 1'b1;
                end
                if ($urandom_range(0, 19) == 0) enable[c] = ~enable[c];
            end
            cycle();
            load = '0;
        end

        // Asynchronous reset in the middle of a clock phase
        enable = '1;
        repeat (5) cycle();
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        for (int c = 0; c < CH; c++) begin
            check("rst_outclk", c, int'(outclk[c]), 0);
            check("rst_outclk_n", c, int'(outclk_n[c]), 1);
            check("rst_tick", c, int'(tick[c]), 0);
            check("rst_active", c, int'(active[c]), 0);
        end
        repeat (2) @(posedge inclk);
        @(negedge inclk);
        Reset = 1'b0;
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
